// File: rtl/dlfloat_operand_loader.sv
`default_nettype none
// ============================================================================
// dlfloat_operand_loader: pairs DLFloat16 words into sanitised A/B operands
// and queues them in a small FIFO for the MAC.
// Rev 1.0
// ============================================================================
module dlfloat_operand_loader #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_word,
  output logic        in_ready,
  input  logic        flush,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [3:0]  op_flags,
  output logic [7:0]  pair_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        a_q, a_d;
  logic [1:0]         a_flags_q, a_flags_d;
  logic [35:0]        mem_q [DEPTH];
  logic [35:0]        mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         pair_count_q, pair_count_d;

  logic [17:0]        w_san;
  logic               w_full;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;

  // Returns {word, zero_flag, special_flag}; subnormals flush to signed zero.
  function automatic logic [17:0] sanitise(input logic [15:0] w);
    case (w[14:9])
      6'd0:    return {w[15], 15'h0000, 2'b10};
      6'd63:   return {w[15], 15'h7FFF, 2'b01};
      default: return {w, 2'b00};
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    a_flags_d    = a_flags_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pair_count_d = pair_count_q;
    w_push       = 1'b0;

    w_san    = sanitise(in_word);
    w_full   = (count_q == FULL_COUNT);
    in_ready = !((state_q == WAIT_B) && w_full);
    op_valid = (count_q != '0);
    w_accept = in_valid && in_ready;
    w_pop    = op_valid && op_ready;

    // A flush coinciding with an accepted word restarts the pair with that word.
    if (w_accept) begin
      if ((state_q == WAIT_A) || flush) begin
        a_d       = w_san[17:2];
        a_flags_d = w_san[1:0];
        state_d   = WAIT_B;
      end else begin
        w_push  = 1'b1;
        state_d = WAIT_A;
      end
    end else if (flush) begin
      state_d = WAIT_A;
    end

    if (w_push) begin
      mem_d[wr_ptr_q] = {a_q, w_san[17:2], a_flags_q, w_san[1:0]};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    if (w_pop) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      pair_count_d = pair_count_q + 8'd1;
    end

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_A;
      a_q          <= '0;
      a_flags_q    <= '0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pair_count_q <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      a_flags_q    <= a_flags_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pair_count_q <= pair_count_d;
    end
  end

  assign op_a       = mem_q[rd_ptr_q][35:20];
  assign op_b       = mem_q[rd_ptr_q][19:4];
  assign op_flags   = mem_q[rd_ptr_q][3:0];
  assign pair_count = pair_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dlfloat_operand_loader.sv
`default_nettype none
// ============================================================================
// tb_dlfloat_operand_loader: scoreboard bench with a pairing/queue reference
// model, directed scenarios and randomized traffic.
// Rev 1.0
// ============================================================================
module tb_dlfloat_operand_loader;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_word;
  logic        in_ready;
  logic        flush;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  op_flags;
  logic [7:0]  pair_count;

  dlfloat_operand_loader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_word    (in_word),
    .in_ready   (in_ready),
    .flush      (flush),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_flags   (op_flags),
    .pair_count (pair_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: pending A, queued pairs, consumed-pair counter.
  logic [35:0] sb [$];
  logic        have_a  = 1'b0;
  logic [17:0] a_exp   = '0;
  int          occ     = 0;
  logic [7:0]  cnt     = '0;
  logic        fresh   = 1'b0;
  logic        started = 1'b0;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {word, zero, special} from the DLFloat16 field rules.
  function automatic logic [17:0] ref_san(input logic [15:0] w);
    int e;
    e = (int'(w) / 512) % 64;
    if (e == 0)  return {w & 16'h8000, 1'b1, 1'b0};
    if (e == 63) return {w | 16'h7FFF, 1'b0, 1'b1};
    return {w, 2'b00};
  endfunction

  always @(negedge clk) begin
    #1;
    if (rst) begin
      sb.delete();
      occ     = 0;
      have_a  = 1'b0;
      a_exp   = '0;
      cnt     = '0;
      fresh   = 1'b1;
      started = 1'b1;
    end else if (started) begin
      logic ready;
      logic acc;
      logic [17:0] w;
      ready = !(have_a && occ == DEPTH);
      acc   = in_valid && ready;
      if (op_ready && occ > 0) begin
        occ--;
        cnt = cnt + 8'd1;
      end
      w = ref_san(in_word);
      if (acc) begin
        if (!have_a || flush) begin
          a_exp  = w;
          have_a = 1'b1;
        end else begin
          sb.push_back({a_exp[17:2], w[17:2], a_exp[1:0], w[1:0]});
          occ++;
          have_a = 1'b0;
          fresh  = 1'b0;
        end
      end else if (flush) begin
        have_a = 1'b0;
      end
    end
  end

  // Monitor: compares DUT outputs to the model and retires consumed pairs.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", {35'd0, in_ready}, {35'd0, !(have_a && occ == DEPTH)});
      chk("op_valid", {35'd0, op_valid}, {35'd0, sb.size() != 0});
      chk("pair_count", {28'd0, pair_count}, {28'd0, cnt});
      if (sb.size() != 0) begin
        chk("head_pair", {op_a, op_b, op_flags}, sb[0]);
        if (op_ready && !rst) void'(sb.pop_front());
      end else if (fresh) begin
        chk("reset_outputs", {op_a, op_b, op_flags}, 36'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic send(input logic [15:0] w);
    in_valid = 1'b1;
    in_word  = w;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) begin
        cyc();
        in_valid = 1'b0;
        return;
      end
      cyc();
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: word %0h not accepted within 40 cycles", w);
    in_valid = 1'b0;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom % 4)
      0:       w[14:9] = 6'd0;
      1:       w[14:9] = 6'd63;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_word = '0; flush = 1'b0; op_ready = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    idle(2);

    // Normal pair, immediate consumption.
    op_ready = 1'b1;
    send(16'h3EA3); send(16'h4073);
    idle(4);

    // Sanitising: subnormal / special on both operands.
    send(16'h01B2); send(16'h7FC0);
    send(16'hFFFF); send(16'h8000);
    idle(4);

    // Backpressure with a full FIFO, then one pop frees a slot.
    op_ready = 1'b0;
    send(16'h3C01); send(16'h3C02); send(16'h3C03); send(16'h3C04); send(16'h3C05);
    in_valid = 1'b1; in_word = 16'h3C06;
    repeat (3) cyc();
    op_ready = 1'b1;
    cyc();
    op_ready = 1'b0;
    send(16'h3C06);
    idle(2);
    op_ready = 1'b1;
    idle(6);

    // Flush of a held A, flush with a simultaneous word, flush while idle.
    send(16'hBEA3);
    flush = 1'b1; cyc(); flush = 1'b0;
    send(16'hC073); send(16'h3EA3);
    idle(3);
    send(16'h4000);
    flush = 1'b1; send(16'h4200); flush = 1'b0;
    send(16'h4400);
    idle(3);
    flush = 1'b1; cyc(); flush = 1'b0;
    send(16'h3C00); send(16'h3E00);
    idle(3);

    // Reset with pairs queued and an A held.
    op_ready = 1'b0;
    send(16'h4001); send(16'h4002); send(16'h4003); send(16'h4004); send(16'h4005);
    rst = 1'b1; cyc(); rst = 1'b0;
    op_ready = 1'b1;
    idle(4);

    // 256 consumed pairs: pair_count wraps back to zero.
    for (int i = 0; i < 512; i++) send(rand_word());
    idle(4);

    // Randomized traffic including flush and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom % 4) != 0;
      in_word  = rand_word();
      op_ready = ($urandom % 3) != 0;
      flush    = ($urandom % 16) == 0;
      rst      = ($urandom % 300) == 0;
      cyc();
    end
    rst = 1'b0; flush = 1'b0; op_ready = 1'b1;
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dlfloat_operand_loader.md
DLFLOAT_OPERAND_LOADER -- requirements
Module: dlfloat_operand_loader

Interface
REQ-001 Parameter: DEPTH, 2, number of operand-pair FIFO entries (power of two, 2..8).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: in_valid  input  1  a 16-bit DLFloat16 word is offered on in_word.
REQ-005 Port: in_word  input  16  operand word, {uio_in, ui_in} ordering, i.e. msb byte in [15:8].
REQ-006 Port: in_ready  output  1  loader accepts in_word this cycle.
REQ-007 Port: flush  input  1  discards a held, unpaired A operand.
REQ-008 Port: op_valid  output  1  an operand pair is presented to the MAC.
REQ-009 Port: op_ready  input  1  MAC consumes the presented pair this cycle.
REQ-010 Port: op_a  output  16  sanitised operand A of head pair.
REQ-011 Port: op_b  output  16  sanitised operand B of head pair.
REQ-012 Port: op_flags  output  4  {a_zero, a_special, b_zero, b_special} of head pair.
REQ-013 Port: pair_count  output  8  number of pairs consumed by the MAC since reset.

Function
REQ-014 Word format SHALL be DLFloat16: sign [15], exponent [14:9] (bias 31), mantissa [8:0].
REQ-015 Input accepted only when in_valid && in_ready at a rising edge.
REQ-016 Pairing FSM SHALL have two states: WAIT_A (next word is A) and WAIT_B (A held, next word is B).
REQ-017 WAIT_A: accepted word stored in A register, go to WAIT_B; accepted regardless of FIFO fill.
REQ-018 WAIT_B: accepted word completes the pair, pair {A,B,flags} pushed to FIFO tail, go to WAIT_A.
REQ-019 in_ready SHALL be 0 only when state==WAIT_B and FIFO full; in_ready SHALL NOT depend combinationally on op_ready.
REQ-020 Sanitising, applied at capture: exponent==0 -> word forced to {sign,15'h0000}, zero flag=1 (subnormals flush to zero).
REQ-021 Exponent==63 -> word forced to {sign,15'h7FFF}, special flag=1.
REQ-022 Otherwise the word SHALL pass unchanged with both flags 0.
REQ-023 op_valid SHALL equal FIFO-not-empty; op_a/op_b/op_flags always reflect the FIFO head.
REQ-024 While op_valid && !op_ready, op_a, op_b, op_flags SHALL hold stable.
REQ-025 Latency: B accepted at edge N into empty FIFO -> op_valid=1 with that pair in the cycle after edge N.
REQ-026 Pop on op_valid && op_ready; simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-027 op_ready while op_valid=0 SHALL be ignored; no underflow.
REQ-028 pair_count SHALL increment by 1 per pop, wrapping 255 -> 0.
REQ-029 flush in WAIT_B SHALL discard A and return to WAIT_A; FIFO contents and pair_count unaffected.
REQ-030 flush in WAIT_A SHALL have no effect.
REQ-031 flush with a simultaneous accepted word SHALL take priority: the word is captured as a new A and state becomes WAIT_B.
REQ-032 FIFO pointers wrap modulo DEPTH; full when occupancy==DEPTH.

Reset
REQ-033 rst=1 at an edge SHALL force state WAIT_A, FIFO empty, A register 0, pair_count 0; overrides all other inputs that cycle.
REQ-034 During and after reset: in_ready=1, op_valid=0, op_a=0, op_b=0, op_flags=0.
REQ-035 Reset mid-pair or with FIFO occupied SHALL discard all held operands; no pair is presented afterwards.

Verification
REQ-036 Words 0x3EA3 then 0x4073, op_ready=1 -> next cycle op_valid=1, op_a=0x3EA3, op_b=0x4073, op_flags=0000; pair_count=1 after pop.
REQ-037 Words 0x01B2 then 0x7FC0 -> op_a=0x0000, op_b=0x7FFF, op_flags=1001; words 0xFFFF, 0x8000 -> op_a=0xFFFF, op_b=0x8000, op_flags=0110.
REQ-038 op_ready=0, DEPTH=2, stream six words -> two pairs queued, fifth word accepted as A, in_ready=0 with sixth offered; one op_ready pulse -> in_ready=1 the following cycle, order 1,2,3 preserved.
REQ-039 Word 0xBEA3 accepted, then flush, then 0xC073, 0x3EA3 -> single pair op_a=0xC073, op_b=0x3EA3.
REQ-040 Two pairs queued, rst pulsed one cycle -> op_valid=0, pair_count=0, in_ready=1; 256 pops -> pair_count wraps to 0.
